// File: rtl/argmax_select_if.sv
// Handshake bundle for argmax_select: vector in, winning class/score out.
// Parameters must match the argmax_select instance it is bound to.
interface argmax_select_if #(
  parameter int unsigned NUM_CLASSES       = 10,
  parameter int unsigned NORM_OUT_BITWIDTH = 16
);
  localparam int unsigned IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic [NORM_OUT_BITWIDTH*NUM_CLASSES-1:0] in_vector;
  logic                                     in_valid;
  logic                                     in_ready;
  logic [IDX_W-1:0]                         out_class;
  logic [NORM_OUT_BITWIDTH-1:0]             out_value;
  logic                                     out_confident;
  logic                                     out_valid;
  logic                                     out_ready;

  modport master (
    output in_vector, in_valid, out_ready,
    input  in_ready, out_class, out_value, out_confident, out_valid
  );

  modport slave (
    input  in_vector, in_valid, out_ready,
    output in_ready, out_class, out_value, out_confident, out_valid
  );
endinterface

// File: rtl/argmax_select.sv
// Sequential argmax over a captured score vector: one class compared per cycle,
// ties resolve to the lowest index, result held until the consumer takes it.
module argmax_select #(
  parameter int unsigned                NUM_CLASSES       = 10,
  parameter int unsigned                NORM_OUT_BITWIDTH = 16,
  parameter logic [NORM_OUT_BITWIDTH-1:0] CONF_THRESHOLD  = 16'h8000
) (
  input logic           clock,
  input logic           reset,
  argmax_select_if.slave bus
);
  localparam int unsigned IDX_W    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned W        = NORM_OUT_BITWIDTH;
  localparam int unsigned NumSlots = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic [W-1:0]           max_val_q, max_val_d;
  logic [IDX_W-1:0]       max_idx_q, max_idx_d;
  logic [W*NUM_CLASSES-1:0] vec_q, vec_d;
  logic [IDX_W-1:0]       res_class_q;
  logic [W-1:0]           res_value_q;
  logic                   res_conf_q;
  logic                   load_result;

  // Padded to a power of two so the counter can index without a width mismatch.
  logic [W-1:0] score [NumSlots];
  for (genvar k = 0; k < NumSlots; k++) begin : g_score
    if (k < NUM_CLASSES) begin : g_real
      assign score[k] = vec_q[W*k +: W];
    end else begin : g_pad
      assign score[k] = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    vec_d     = vec_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          vec_d     = bus.in_vector;
          max_val_d = bus.in_vector[W-1:0];
          max_idx_d = '0;
          cnt_d     = IDX_W'(1);
          state_d   = (NUM_CLASSES > 1) ? StScan : StDone;
        end
      end
      StScan: begin
        if (score[cnt_q] > max_val_q) begin
          max_val_d = score[cnt_q];
          max_idx_d = cnt_q;
        end
        if (cnt_q == LastIdx) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Result registers load once on entry to DONE and persist until the next result.
  assign load_result = (state_d == StDone) && (state_q != StDone);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      max_val_q   <= '0;
      max_idx_q   <= '0;
      vec_q       <= '0;
      res_class_q <= '0;
      res_value_q <= '0;
      res_conf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      vec_q     <= vec_d;
      if (load_result) begin
        res_class_q <= max_idx_d;
        res_value_q <= max_val_d;
        res_conf_q  <= (max_val_d >= CONF_THRESHOLD);
      end
    end
  end

  assign bus.in_ready      = (state_q == StIdle);
  assign bus.out_valid     = (state_q == StDone);
  assign bus.out_class     = res_class_q;
  assign bus.out_value     = res_value_q;
  assign bus.out_confident = res_conf_q;
endmodule

// File: tb/tb_argmax_select.sv
// Directed bench for argmax_select: default 10-class build plus a 1-class build.
module tb_argmax_select;
  localparam int N = 10;
  localparam int W = 16;

  logic clock = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  argmax_select_if #(.NUM_CLASSES(N), .NORM_OUT_BITWIDTH(W)) bus ();
  argmax_select_if #(.NUM_CLASSES(1), .NORM_OUT_BITWIDTH(W)) bus1 ();

  argmax_select #(.NUM_CLASSES(N), .NORM_OUT_BITWIDTH(W), .CONF_THRESHOLD(16'h8000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  argmax_select #(.NUM_CLASSES(1), .NORM_OUT_BITWIDTH(W), .CONF_THRESHOLD(16'h8000)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  // Present vec for one accept edge, scramble in_vector afterwards, and count edges
  // (accept edge = 1) until out_valid is seen, bounded at 50.
  task automatic send(input logic [N*W-1:0] vec, output int lat);
    bus.in_vector = vec;
    bus.in_valid  = 1'b1;
    @(posedge clock); #1;
    bus.in_valid  = 1'b0;
    bus.in_vector = '1;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors += 6;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    if (bus.out_class !== 4'd0) begin
      miscompares++; $display("FAIL reset_out_class: got %0d want 0", bus.out_class);
    end
    if (bus.out_value !== 16'h0) begin
      miscompares++; $display("FAIL reset_out_value: got %h want 0000", bus.out_value);
    end
    if (bus.out_confident !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_conf: got %b want 0", bus.out_confident);
    end
    if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_n1_hs: got ready=%b valid=%b want 1/0", bus1.in_ready, bus1.out_valid);
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_ascending();
    logic [N*W-1:0] v;
    int lat;
    for (int k = 0; k < N; k++) v[k*W +: W] = 16'(100 * (k + 1));
    send(v, lat);
    vectors += 4;
    if (lat !== 10) begin
      miscompares++; $display("FAIL asc_latency: got %0d want 10", lat);
    end
    if (bus.out_class !== 4'd9) begin
      miscompares++; $display("FAIL asc_class: got %0d want 9", bus.out_class);
    end
    if (bus.out_value !== 16'd1000) begin
      miscompares++; $display("FAIL asc_value: got %0d want 1000", bus.out_value);
    end
    if (bus.out_confident !== 1'b0) begin
      miscompares++; $display("FAIL asc_conf: got %b want 0", bus.out_confident);
    end
    release_result();
    vectors += 2;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL asc_release: got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    if (bus.out_class !== 4'd9 || bus.out_value !== 16'd1000) begin
      miscompares++;
      $display("FAIL asc_retain: got %0d/%0d want 9/1000", bus.out_class, bus.out_value);
    end
  endtask

  task automatic test_tie();
    logic [N*W-1:0] v;
    int lat;
    for (int k = 0; k < N; k++) v[k*W +: W] = 16'h0100;
    v[3*W +: W] = 16'h9000;
    v[7*W +: W] = 16'h9000;
    send(v, lat);
    vectors += 4;
    if (lat !== 10) begin
      miscompares++; $display("FAIL tie_latency: got %0d want 10", lat);
    end
    if (bus.out_class !== 4'd3) begin
      miscompares++; $display("FAIL tie_class: got %0d want 3", bus.out_class);
    end
    if (bus.out_value !== 16'h9000) begin
      miscompares++; $display("FAIL tie_value: got %h want 9000", bus.out_value);
    end
    if (bus.out_confident !== 1'b1) begin
      miscompares++; $display("FAIL tie_conf: got %b want 1", bus.out_confident);
    end
    release_result();
  endtask

  task automatic test_hold();
    logic [N*W-1:0] v;
    int lat;
    for (int k = 0; k < N; k++) v[k*W +: W] = 16'h0010;
    v[5*W +: W] = 16'h1234;
    send(v, lat);
    vectors++;
    if (lat !== 10) begin
      miscompares++; $display("FAIL hold_latency: got %0d want 10", lat);
    end
    for (int i = 0; i < 20; i++) begin
      bus.in_valid  = i[0];
      bus.in_vector = {N{16'hFFFF - 16'(i)}};
      @(posedge clock); #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_class !== 4'd5 ||
          bus.out_value !== 16'h1234 || bus.out_confident !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: got v=%b r=%b c=%0d val=%h cf=%b want 1/0/5/1234/0", i,
                 bus.out_valid, bus.in_ready, bus.out_class, bus.out_value, bus.out_confident);
      end
    end
    bus.in_valid = 1'b0;
    release_result();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [N*W-1:0] v;
    int lat;
    for (int k = 0; k < N; k++) v[k*W +: W] = 16'h0500;
    v[8*W +: W] = 16'hA000;
    bus.in_vector = v;
    bus.in_valid  = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    vectors += 2;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_scan_hs: got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    if (bus.out_class !== 4'd0 || bus.out_value !== 16'h0 || bus.out_confident !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_scan_out: got %0d/%h/%b want 0/0000/0", bus.out_class, bus.out_value,
               bus.out_confident);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    // Accept must happen on the very first edge after deassertion.
    for (int k = 0; k < N; k++) v[k*W +: W] = 16'hFFFE;
    v[0 +: W]   = 16'hFFFF;
    v[9*W +: W] = 16'hFFFF;
    send(v, lat);
    vectors += 3;
    if (lat !== 10) begin
      miscompares++; $display("FAIL rst_next_latency: got %0d want 10", lat);
    end
    if (bus.out_class !== 4'd0 || bus.out_value !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL rst_next_result: got %0d/%h want 0/ffff", bus.out_class, bus.out_value);
    end
    if (bus.out_confident !== 1'b1) begin
      miscompares++; $display("FAIL rst_next_conf: got %b want 1", bus.out_confident);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] v;
    int hits[$];
    bit cls_ok = 1'b1;
    for (int k = 0; k < N; k++) v[k*W +: W] = 16'(k * 16);
    v[6*W +: W] = 16'h8000;
    bus.in_vector = v;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      @(posedge clock); #1;
      if (bus.out_valid) begin
        hits.push_back(c);
        if (bus.out_class !== 4'd6 || bus.out_value !== 16'h8000 || bus.out_confident !== 1'b1)
          cls_ok = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    vectors += 3;
    if (hits.size() !== 3) begin
      miscompares++; $display("FAIL b2b_count: got %0d want 3", hits.size());
    end else if (hits[0] !== 10 || hits[1] !== 21 || hits[2] !== 32) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d,%0d,%0d want 10,21,32", hits[0], hits[1], hits[2]);
    end
    if (cls_ok !== 1'b1) begin
      miscompares++; $display("FAIL b2b_result: got wrong result, want 6/8000/1");
    end
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_idle: got ready=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_single_class();
    int hits[$];
    bus1.in_vector = 16'h8000;
    bus1.in_valid  = 1'b1;
    @(posedge clock); #1;
    bus1.in_valid = 1'b0;
    vectors += 2;
    if (bus1.out_valid !== 1'b1) begin
      miscompares++; $display("FAIL n1_latency: got valid=%b want 1", bus1.out_valid);
    end
    if (bus1.out_class !== 1'b0 || bus1.out_value !== 16'h8000 || bus1.out_confident !== 1'b1) begin
      miscompares++;
      $display("FAIL n1_result: got %0d/%h/%b want 0/8000/1", bus1.out_class, bus1.out_value,
               bus1.out_confident);
    end
    bus1.out_ready = 1'b1;
    @(posedge clock); #1;
    bus1.in_vector = 16'h7FFF;
    bus1.in_valid  = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
      if (bus1.out_valid) hits.push_back(c);
    end
    bus1.in_valid = 1'b0;
    vectors += 2;
    if (hits.size() !== 5 || hits[0] !== 1 || hits[1] !== 3) begin
      miscompares++;
      $display("FAIL n1_stream: got %0d hits first=%0d want 5 hits at 1,3,..",
               hits.size(), (hits.size() > 0) ? hits[0] : -1);
    end
    if (bus1.out_value !== 16'h7FFF || bus1.out_confident !== 1'b0) begin
      miscompares++;
      $display("FAIL n1_stream_val: got %h/%b want 7fff/0", bus1.out_value, bus1.out_confident);
    end
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_vector  = '0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus1.in_vector = '0;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
    test_reset();
    test_ascending();
    test_tie();
    test_hold();
    test_reset_mid_scan();
    test_back_to_back();
    test_single_class();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion want finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/argmax_select.md
ARGMAX_SELECT -- requirements
Module: argmax_select

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10: number of class scores per vector; legal range 1..256.
REQ-002 SHALL have parameter NORM_OUT_BITWIDTH, default 16: width of each normalized score, unsigned.
REQ-003 SHALL have parameter CONF_THRESHOLD, default 16'h8000: minimum winning score for out_confident.
REQ-004 SHALL derive IDX_W = max(1, ceil(log2(NUM_CLASSES))).
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_vector  input  NORM_OUT_BITWIDTH*NUM_CLASSES  normalized scores from the softmax normalize stage; class k occupies bits [NORM_OUT_BITWIDTH*(k+1)-1 : NORM_OUT_BITWIDTH*k].
REQ-008 SHALL have port in_valid  input  1  in_vector holds a valid vector.
REQ-009 SHALL have port in_ready  output  1  block accepts a vector this cycle.
REQ-010 SHALL have port out_class  output  IDX_W  index of winning class.
REQ-011 SHALL have port out_value  output  NORM_OUT_BITWIDTH  score of winning class.
REQ-012 SHALL have port out_confident  output  1  out_value >= CONF_THRESHOLD.
REQ-013 SHALL have port out_valid  output  1  out_class/out_value/out_confident are valid.
REQ-014 SHALL have port out_ready  input  1  consumer takes the result this cycle.

Function
REQ-015 SHALL implement states IDLE, SCAN, DONE; in_ready = (state==IDLE) combinationally; out_valid = (state==DONE) combinationally.
REQ-016 SHALL accept a vector on a rising edge where in_valid && in_ready: capture full in_vector into an internal register, load max_val <= class 0 score, max_idx <= 0, scan counter <= 1.
REQ-017 On accept SHALL go to SCAN if NUM_CLASSES > 1, else directly to DONE.
REQ-018 In SCAN, each cycle SHALL compare captured score[counter] against max_val as unsigned; if strictly greater, max_val <= score[counter], max_idx <= counter; counter increments by 1.
REQ-019 SHALL leave SCAN for DONE on the edge that processes counter == NUM_CLASSES-1; counter never wraps or indexes beyond NUM_CLASSES-1.
REQ-020 Ties SHALL resolve to the lowest class index (strict greater-than only).
REQ-021 Latency SHALL be exactly NUM_CLASSES cycles from accept edge to out_valid high (1 cycle when NUM_CLASSES==1).
REQ-022 in_vector changes after the accept edge SHALL NOT affect the result.
REQ-023 In DONE, out_class/out_value/out_confident SHALL hold stable until the edge where out_ready is high; on that edge state SHALL return to IDLE.
REQ-024 out_ready while not in DONE SHALL be ignored; in_valid while not in IDLE SHALL be ignored and not captured.
REQ-025 Back-to-back throughput SHALL be one vector per NUM_CLASSES+1 cycles with out_ready held high (DONE->IDLE->accept).
REQ-026 out_confident SHALL be registered, computed from the final max_val, and valid whenever out_valid is high.
REQ-027 out_class, out_value, out_confident SHALL retain last result after leaving DONE until the next result overwrites them.

Reset
REQ-028 While reset is high, state SHALL be IDLE, counter, max_val, max_idx, captured vector and out_confident SHALL be 0, asynchronously.
REQ-029 During and after reset: in_ready=1, out_valid=0, out_class=0, out_value=0, out_confident=0.
REQ-030 Reset asserted mid-SCAN or in DONE SHALL abandon the vector with no result ever presented.
REQ-031 The first rising edge after reset deassertion SHALL be able to accept a vector.

Verification
REQ-032 Defaults, scores [0..9] = 100,200,...,1000 (class 9 max), in_valid 1 cycle -> out_valid exactly 10 cycles later, out_class=9, out_value=1000, out_confident=0.
REQ-033 Scores all 0x0100 except classes 3 and 7 = 0x9000 -> out_class=3, out_value=0x9000, out_confident=1 (tie, lowest index).
REQ-034 Result ready, hold out_ready=0 for 20 cycles while toggling in_valid and in_vector -> outputs stable, in_ready=0, no capture; out_ready=1 -> IDLE next cycle.
REQ-035 Assert reset at SCAN cycle 4 -> out_valid never rises for that vector; next vector accepted and class 0 = 0xFFFF max gives out_class=0, out_value=0xFFFF.
REQ-036 NUM_CLASSES=1 build, score 0x8000 -> out_valid 1 cycle after accept, out_class=0, out_confident=1; streaming with out_ready=1 yields one result every NUM_CLASSES+1 cycles.
